// File: rtl/freq_div_pkg.sv
// Shared types and constants for the synchronous divided-clock controller.
package freq_div_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam int MIN_DIV = 2;
  localparam int RST_DIV = 2;

endpackage

// File: rtl/div_counter.sv
// Period counter with registered tick and divided waveform.
// en/div are the values that will hold in the next cycle, so tick/div_out line up with cnt.
module div_counter
  import freq_div_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [CNT_W-1:0] div,
  output logic             tick,
  output logic             div_out
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             run_q;
  logic             tick_q, tick_d;
  logic             div_out_q, div_out_d;

  // Next count: restart on run entry and after the last cycle of a period.
  always_comb begin
    cnt_d = cnt_q;
    if (!en) begin
      cnt_d = '0;
    end else if (!run_q || tick_q) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    tick_d    = en & (cnt_d == (div - CNT_W'(1)));
    div_out_d = en & (cnt_d < (div >> 1));
  end

  // Counter and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      run_q     <= 1'b0;
      tick_q    <= 1'b0;
      div_out_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      run_q     <= en;
      tick_q    <= tick_d;
      div_out_q <= div_out_d;
    end
  end

  assign tick    = tick_q;
  assign div_out = div_out_q;

endmodule

// File: rtl/freq_div_ctrl.sv
// Divided-clock controller: run FSM, one-entry config shadow, period bookkeeping.
// New divisors only take effect at period boundaries.
module freq_div_ctrl
  import freq_div_pkg::*;
#(
  parameter int CNT_W   = 8,
  parameter int BURST_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [CNT_W-1:0]   cfg_div,
  input  logic [BURST_W-1:0] cfg_burst,
  input  logic               start,
  input  logic               stop,
  output logic               tick,
  output logic               div_out,
  output logic               busy,
  output logic               done,
  output logic               err
);

  localparam logic [BURST_W-1:0] PER_MAX = '1;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     act_div_q, act_div_d;
  logic [BURST_W-1:0]   act_burst_q, act_burst_d;
  logic [BURST_W-1:0]   run_burst_q, run_burst_d;
  logic [CNT_W-1:0]     sh_div_q, sh_div_d;
  logic [BURST_W-1:0]   sh_burst_q, sh_burst_d;
  logic                 sh_vld_q, sh_vld_d;
  logic [BURST_W-1:0]   per_cnt_q, per_cnt_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 err_q, err_d;
  logic                 cfg_ready_q, cfg_ready_d;
  logic                 accept, legal, promote, last_tick;
  logic [BURST_W-1:0]   per_inc;

  // Handshake, shadow promotion, FSM and period counting.
  always_comb begin
    state_d     = state_q;
    run_burst_d = run_burst_q;
    sh_div_d    = sh_div_q;
    sh_burst_d  = sh_burst_q;
    per_cnt_d   = per_cnt_q;
    done_d      = 1'b0;

    accept    = cfg_valid & cfg_ready_q;
    legal     = cfg_div >= CNT_W'(MIN_DIV);
    promote   = sh_vld_q & ((state_q == IDLE) | tick);
    per_inc   = per_cnt_q + BURST_W'(1);
    last_tick = tick & (run_burst_q != '0) & (per_inc == run_burst_q);
    err_d     = accept & ~legal;

    if (promote) begin
      act_div_d   = sh_div_q;
      act_burst_d = sh_burst_q;
    end else begin
      act_div_d   = act_div_q;
      act_burst_d = act_burst_q;
    end

    // accept and promote are exclusive: accept needs an empty shadow.
    if (accept && legal) begin
      sh_div_d   = cfg_div;
      sh_burst_d = cfg_burst;
      sh_vld_d   = 1'b1;
    end else if (promote) begin
      sh_vld_d   = 1'b0;
    end else begin
      sh_vld_d   = sh_vld_q;
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d     = RUN;
          per_cnt_d   = '0;
          run_burst_d = act_burst_d;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        if (tick && (per_cnt_q != PER_MAX)) begin
          per_cnt_d = per_inc;
        end else begin
          per_cnt_d = per_cnt_q;
        end
        if (last_tick) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else if (stop) begin
          state_d = DRAIN;
        end else begin
          state_d = RUN;
        end
      end
      DRAIN: begin
        if (tick && (per_cnt_q != PER_MAX)) begin
          per_cnt_d = per_inc;
        end else begin
          per_cnt_d = per_cnt_q;
        end
        if (tick) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          state_d = DRAIN;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d      = (state_d != IDLE);
    cfg_ready_d = ~sh_vld_d;
  end

  // Controller state and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      act_div_q   <= CNT_W'(RST_DIV);
      act_burst_q <= '0;
      run_burst_q <= '0;
      sh_div_q    <= '0;
      sh_burst_q  <= '0;
      sh_vld_q    <= 1'b0;
      per_cnt_q   <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      cfg_ready_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      act_div_q   <= act_div_d;
      act_burst_q <= act_burst_d;
      run_burst_q <= run_burst_d;
      sh_div_q    <= sh_div_d;
      sh_burst_q  <= sh_burst_d;
      sh_vld_q    <= sh_vld_d;
      per_cnt_q   <= per_cnt_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      cfg_ready_q <= cfg_ready_d;
    end
  end

  div_counter #(
    .CNT_W(CNT_W)
  ) u_div_counter (
    .clk     (clk),
    .rst_n   (rst_n),
    .en      (busy_d),
    .div     (act_div_d),
    .tick    (tick),
    .div_out (div_out)
  );

  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign cfg_ready = cfg_ready_q;

endmodule

// File: doc/freq_div_ctrl.md
# freq_div_ctrl

Programmable, fully synchronous divided-clock controller that replaces ripple-clocked flip-flop chains for new designs. It produces a one-cycle `tick` enable and a registered divided waveform `div_out` from the single system clock. It accepts divisor/burst configuration over a valid/ready handshake and applies new divisors only at period boundaries, so no period is ever shortened or stretched. Consumers clock on `clk` and qualify with `tick`; `div_out` is a data signal, never a clock.

## Interface
- `CNT_W`, default 8: divisor width. Legal divisors are 2..2^CNT_W-1.
- `BURST_W`, default 8: burst-length width. A burst of 0 means continuous.
- `clk`  in  1  system clock; all logic on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset. Assertion is immediate; release is synchronous to `clk`.
- `cfg_valid`  in  1  configuration offered.
- `cfg_ready`  out  1  configuration can be accepted. Transfer occurs when `cfg_valid & cfg_ready`.
- `cfg_div`  in  CNT_W  requested divisor D.
- `cfg_burst`  in  BURST_W  requested number of periods per run. 0 means run until stopped.
- `start`  in  1  level-sampled; begins a run when in IDLE.
- `stop`  in  1  level-sampled; requests a graceful stop when in RUN.
- `tick`  out  1  one-cycle pulse on the last cycle of each period.
- `div_out`  out  1  registered divided waveform.
- `busy`  out  1  high in RUN or DRAIN.
- `done`  out  1  one-cycle pulse when a run ends.
- `err`  out  1  one-cycle pulse when a handshake carries `cfg_div` < 2.

## Operation
- **Registers**
  - `act_div`: active divisor.
  - `act_burst`: active burst length.
  - `sh_div`, `sh_burst`, `sh_vld`: one-entry shadow holding a pending configuration.
  - `cnt`: period counter, 0..act_div-1.
  - `per_cnt`: completed-period counter.
- **Reset values**
  - Registers: `act_div`=2, `act_burst`=0, `sh_vld`=0, `cnt`=0, `per_cnt`=0, state IDLE.
  - Outputs: `tick`=0, `div_out`=0, `busy`=0, `done`=0, `err`=0, `cfg_ready`=0. `cfg_ready` goes to 1 on the first cycle after reset release.
- **Configuration**
  - `cfg_ready` = !`sh_vld`.
  - An accepted config with `cfg_div` < 2 is discarded: `err` pulses on the next cycle and the shadow is unchanged.
  - A legal accepted config is written to the shadow and `sh_vld` is set.
  - The shadow is promoted to `act_*` (and `sh_vld` cleared) on the first of these, strictly after the accept cycle:
    - a cycle in IDLE;
    - a cycle in RUN/DRAIN where `tick`=1.
  - `act_burst` is only consulted at start. A promoted burst value affects the next run, not the current one.
- **State machine** (states IDLE, RUN, DRAIN)
  - IDLE + `start` → RUN. `cnt` ← 0 and `per_cnt` ← 0. If the shadow is valid in the same cycle, the run uses the shadow values. `stop` is ignored in IDLE.
  - RUN + `stop` → DRAIN. `start` is ignored while busy.
  - RUN, `tick`, `act_burst`≠0, and `per_cnt`+1 == `act_burst` → IDLE, `done` pulses.
  - DRAIN, `tick` → IDLE, `done` pulses.
  - If a burst's final tick coincides with DRAIN, a single `done` is produced.
- **Datapath**
  - `cnt` increments each busy cycle and wraps from act_div-1 to 0.
  - `tick` = busy & (`cnt` == act_div-1).
  - `div_out` = busy & (`cnt` < act_div>>1).
  - For odd D the waveform is high for floor(D/2) cycles and low for ceil(D/2) cycles.
  - `per_cnt` saturates at 2^BURST_W-1 in continuous mode.

## Timing
- `start` sampled at edge t:
  - `busy`=1 and `cnt`=0 from t+1;
  - first `tick` in cycle t+D;
  - subsequent ticks every D cycles.
- `done` is asserted in the cycle after the final `tick`, with `busy`=0 in that same cycle.
- Divisor change: a config accepted in cycle a takes effect with the period beginning after the first `tick` later than a. No partial periods occur.
- `err` has a latency of 1 cycle from the handshake.
- Reset mid-run: all outputs clear immediately. No `done` is emitted. The shadow is lost.

## Structure
- Package `freq_div_pkg`:
  - `state_t` enum {IDLE, RUN, DRAIN};
  - localparam `MIN_DIV`=2;
  - localparam `RST_DIV`=2.
- Sub-module `div_counter`: holds `cnt`, the wrap compare, `tick` and `div_out` generation. Its inputs are `en` and `div`.
- Top level `freq_div_ctrl`: holds the FSM, the shadow/handshake logic and `per_cnt`.

## Test plan
- Reset, cfg D=4 burst=3, start at cycle 10 → ticks at cycles 14, 18, 22; `done` at cycle 23; `div_out` pattern 1100 repeated three times.
- Continuous D=5, `stop` asserted 2 cycles after a tick → DRAIN; one more tick 3 cycles later, then `done`; no extra periods.
- Running D=3, cfg D=6 accepted mid-period → current period stays 3 cycles; following periods are 6 cycles; `cfg_ready` is low between accept and promotion.
- cfg D=1 and D=0 → `err` pulses 1 cycle after each handshake; `act_div` unchanged; ticks continue at the old rate.
- Config accepted in the same cycle as a `tick` → not promoted at that tick; applied at the next tick.
- `rst_n` asserted asynchronously mid-period (between edges) → outputs go to 0 before the next edge; after release the block is in IDLE with D=2 and `cfg_ready`=1.
